// File: rtl/immgen_pipe_if.sv
// immgen_pipe_if: instruction-in / immediate-out handshake bundle for immgen_pipe.
// Latency: none (wires only).
// Backpressure: carries instr_ready_o upstream and imm_ready_i downstream.
// Ports: instr_valid_i/instr_ready_o/instr_i  upstream instruction handshake
//        imm_valid_o/imm_ready_i/imm_o/imm_type_o  downstream immediate handshake
//        count_o  FIFO occupancy
// Modports: slave is the immgen_pipe side, master is the producer/consumer side.
interface immgen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    logic                     instr_valid_i;
    logic                     instr_ready_o;
    logic [31:0]              instr_i;
    logic                     imm_valid_o;
    logic                     imm_ready_i;
    logic [XLEN-1:0]          imm_o;
    logic [2:0]               imm_type_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  instr_valid_i, instr_i, imm_ready_i,
        output instr_ready_o, imm_valid_o, imm_o, imm_type_o, count_o
    );

    modport master (
        output instr_valid_i, instr_i, imm_ready_i,
        input  instr_ready_o, imm_valid_o, imm_o, imm_type_o, count_o
    );
endinterface

// File: rtl/immgen_pipe.sv
// immgen_pipe: decodes the RV32/RV64 immediate + format of each accepted instruction into a DEPTH-entry FIFO.
// Latency: 1 cycle from acceptance to head of an empty FIFO; no combinational pass-through.
// Backpressure: instr_ready_o = (count < DEPTH) from registered state only; no pop-bypass when full.
// Ports: clk_i, rst_i (async active-high), flush_i (sync clear, beats push/pop),
//        bus (immgen_pipe_if.slave): instruction in, {imm, type} out, occupancy.
// Optional: define IMMGEN_ZICSR_EN to decode SYSTEM/Zicsr immediates (ZIMM and CSR address).
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    immgen_pipe_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_I     = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_B     = 3'd3;
    localparam logic [2:0] IMM_U     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;
    localparam logic [2:0] IMM_SHAMT = 3'd6;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] IMM_ZIMM  = 3'd7;
`endif

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;
`endif

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      itype;
    } entry_t;

    logic [31:0]     instr;
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:2];
    assign funct3 = instr[14:12];

    // ------------------------------------------------------------------
    // Immediate decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_imm  = '0;
        dec_type = IMM_NONE;
        // Compressed encodings carry no immediate here
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OP_LUI, OP_AUIPC: begin
                    dec_imm  = XLEN'($signed({instr[31:12], 12'b0}));
                    dec_type = IMM_U;
                end
                OP_JAL: begin
                    dec_imm  = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                              instr[30:21], 1'b0}));
                    dec_type = IMM_J;
                end
                OP_JALR, OP_LOAD: begin
                    dec_imm  = XLEN'($signed(instr[31:20]));
                    dec_type = IMM_I;
                end
                OP_OP_IMM: begin
                    // funct3 001/101 are the shift-immediate forms
                    if (funct3[1:0] == 2'b01) begin
                        if (XLEN == 64) dec_imm = XLEN'(instr[25:20]);
                        else            dec_imm = XLEN'(instr[24:20]);
                        dec_type = IMM_SHAMT;
                    end else begin
                        dec_imm  = XLEN'($signed(instr[31:20]));
                        dec_type = IMM_I;
                    end
                end
                OP_OP_IMM32: begin
                    // *W forms only exist on RV64; shifts there are always 5-bit
                    if (XLEN == 64) begin
                        if (funct3[1:0] == 2'b01) begin
                            dec_imm  = XLEN'(instr[24:20]);
                            dec_type = IMM_SHAMT;
                        end else begin
                            dec_imm  = XLEN'($signed(instr[31:20]));
                            dec_type = IMM_I;
                        end
                    end
                end
                OP_BRANCH: begin
                    dec_imm  = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                              instr[11:8], 1'b0}));
                    dec_type = IMM_B;
                end
                OP_STORE: begin
                    dec_imm  = XLEN'($signed({instr[31:25], instr[11:7]}));
                    dec_type = IMM_S;
                end
`ifdef IMMGEN_ZICSR_EN
                OP_SYSTEM: begin
                    if (funct3[2] && (funct3[1:0] != 2'b00)) begin
                        dec_imm  = XLEN'(instr[19:15]);
                        dec_type = IMM_ZIMM;
                    end else if (!funct3[2] && (funct3[1:0] != 2'b00)) begin
                        // CSR address is an unsigned index, not a signed offset
                        dec_imm  = XLEN'(instr[31:20]);
                        dec_type = IMM_I;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic            not_empty;
    entry_t          wr_entry;
    entry_t          head;

    assign not_empty = (count_q != '0);
    assign push      = bus.instr_valid_i && bus.instr_ready_o && !flush_i;
    assign pop       = not_empty && bus.imm_ready_i && !flush_i;
    assign wr_entry  = '{imm: dec_imm, itype: dec_type};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.instr_ready_o = (count_q < CW'(DEPTH));
    assign bus.imm_valid_o   = not_empty;
    assign bus.imm_o         = not_empty ? head.imm   : '0;
    assign bus.imm_type_o    = not_empty ? head.itype : IMM_NONE;
    assign bus.count_o       = count_q;
endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Parametrised, buffered successor to the combinational immediate generator; sits at the ID stage output.
- Decodes the RV32/RV64 immediate and its format from each accepted instruction, sign/zero-extends it to XLEN, and queues the result in a DEPTH-entry FIFO.
- Uses valid/ready handshakes on both sides, with flush support for branch mispredict/trap.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all queued entries.
- instr_valid_i  in  1  instr_i is valid.
- instr_ready_o  out  1  FIFO can accept an instruction.
- instr_i  in  32  raw instruction word.
- imm_valid_o  out  1  head entry is valid.
- imm_ready_i  in  1  consumer takes the head entry.
- imm_o  out  XLEN  head immediate.
- imm_type_o  out  3  head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: count_o=0, pointers=0, imm_valid_o=0, imm_o=0, imm_type_o=0, instr_ready_o=1. Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Decode (combinational, on instr_i; selected by instr_i[6:2]):
  - instr_i[1:0]!=2'b11 -> NONE, value 0.
  - LUI, AUIPC -> U: {instr[31:12],12'b0}, sign-extended to XLEN.
  - JAL -> J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}, sign-extended.
  - JALR, LOAD -> I: instr[31:20], sign-extended.
  - OP_IMM with funct3 001/101 -> SHAMT, zero-extended: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - Other OP_IMM -> I.
  - OP_IMM_32 (00110), XLEN=64 only -> I, or SHAMT using instr[24:20] for funct3 001/101. When XLEN=32 -> NONE.
  - BRANCH -> B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, sign-extended.
  - STORE -> S: {instr[31:25],instr[11:7]}, sign-extended.
  - Anything else -> NONE, value 0.
- Push: occurs when instr_valid_i && instr_ready_o && !flush_i.
  - instr_ready_o = (count_o<DEPTH). It depends only on registered state: no combinational ready path, no pop-bypass when full.
- Pop: occurs when imm_valid_o && imm_ready_i. imm_valid_o = (count_o!=0).
- Latency: an instruction accepted at edge N is visible at the head after edge N when the FIFO was empty (1 cycle). There is no combinational pass-through.
- Outputs while empty: imm_o=0 and imm_type_o=0 (gated, not stale).
- Simultaneous push and pop, with 0<count<DEPTH: count unchanged, both pointers advance.
- Full: no push is possible. A pop in the same cycle frees a slot, and ready rises the next cycle.
- Pointers wrap modulo DEPTH. count_o never exceeds DEPTH.
- flush_i has priority over push and pop. Next cycle: count=0, both pointers reset to 0, and any push or pop in the flush cycle is ignored.
- Entries leave in FIFO order. Payload is {imm, type} only.

Optional Feature:
- Macro: IMMGEN_ZICSR_EN.
- When defined, SYSTEM (11100) decodes as follows:
  - funct3 101/110/111 -> ZIMM: zero-extended instr[19:15].
  - funct3 001/010/011 -> I-type value, zero-extended instr[31:20] (the CSR address), reported as type 1.
  - funct3 000 -> NONE.
- When undefined, all SYSTEM encodings -> NONE, value 0. Encoding 7 is never produced.

Test Plan:
- 2 entries queued, imm_ready_i=0, then rst_i pulsed between edges -> immediately count_o=0, imm_valid_o=0, imm_o=0, instr_ready_o=1.
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) then 0xFE000EE3 (beq -4), imm_ready_i=1 -> heads 0xFFFFFFFF/I, then 0xFFFFFFFC/B on consecutive cycles. Each appears one cycle after its acceptance.
- DEPTH=2, imm_ready_i=0, push 0x12345037, 0x008000EF, 0x00000013 -> instr_ready_o=0 after 2 accepts, third held. With imm_ready_i=1: 0x12345000/U, 0x00000008/J, then 0/I in order, ready reasserts the cycle after first pop.
- count=2 with flush_i=1 and instr_valid_i=1 in same cycle -> next cycle count_o=0, imm_valid_o=0, flushed-cycle instruction not stored.
- XLEN=64, push 0x03F09093 (slli x1,x1,63) -> imm_o=63/SHAMT. Push 0xFFF0009B (addiw -1) -> 0xFFFFFFFFFFFFFFFF/I. Same 0x0000009B push with XLEN=32 -> 0/NONE.
- Push 0x3002D073 (csrrwi x0,mstatus,5) -> with IMMGEN_ZICSR_EN: 5/ZIMM. Without: 0/NONE.
